// File: rtl/siggen_pkg.sv
// Shared types and default widths for the delay-line controller.
package siggen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int DEF_ADDRESS_WIDTH = 9;
  localparam int DEF_DATA_WIDTH    = 8;

endpackage

// File: rtl/ram2ports.sv
// Dual-port synchronous RAM: one write port, one read port with registered data.
module ram2ports #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     wr,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDRESS_WIDTH];

  // Storage write; contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (wr) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its last value when not reading.
  always_ff @(posedge clk) begin
    if (rd) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Programmable sample delay line: FILL emits zeros until off_q samples are
// stored, then RUN emits the sample accepted off_q accepts earlier.
module delay_line_ctrl
  import siggen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_sample,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_sample,
  output logic                     filled
);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_fill_cnt;
  logic [ADDRESS_WIDTH-1:0] w_fill_nxt;
  logic [ADDRESS_WIDTH-1:0] w_fill_inc;
  logic [ADDRESS_WIDTH-1:0] r_off;
  logic [ADDRESS_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0]    w_rd_data;
  logic                     w_load_off;
  logic                     w_accept;
  logic                     w_rd;
  logic                     r_out_valid;
  logic                     r_zero;
  logic                     r_filled;

  assign w_accept   = in_valid && ((r_state == FILL) || (r_state == RUN));
  assign w_rd       = w_accept && (r_state == RUN);
  assign w_rd_addr  = r_wr_ptr - r_off;
  assign w_fill_inc = r_fill_cnt + ADDRESS_WIDTH'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; dropping en always wins over fill progress.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_load_off  = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = FILL;
          w_fill_nxt  = '0;
          w_load_off  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FILL: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_fill_nxt  = '0;
        end else if (w_accept) begin
          w_fill_nxt = w_fill_inc;
          if (w_fill_inc == r_off) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = FILL;
          end
        end else begin
          w_state_nxt = FILL;
        end
      end
      RUN: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_fill_nxt  = '0;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_fill_nxt  = '0;
      end
    endcase
  end

  // Datapath registers: write pointer, fill count, latched delay, output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_off       <= ADDRESS_WIDTH'(1);
      r_out_valid <= 1'b0;
      r_zero      <= 1'b1;
      r_filled    <= 1'b0;
    end else begin
      r_fill_cnt  <= w_fill_nxt;
      r_out_valid <= w_accept;
      r_filled    <= (w_state_nxt == RUN);
      if (w_load_off) begin
        r_off <= (offset == '0) ? ADDRESS_WIDTH'(1) : offset;
      end else begin
        r_off <= r_off;
      end
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(1);
        r_zero   <= (r_state != RUN);
      end else begin
        r_wr_ptr <= r_wr_ptr;
        r_zero   <= r_zero;
      end
    end
  end

  ram2ports #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr      (w_accept),
    .wr_addr (r_wr_ptr),
    .wr_data (in_sample),
    .rd      (w_rd),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  assign out_valid  = r_out_valid;
  assign out_sample = r_zero ? '0 : w_rd_data;
  assign filled     = r_filled;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed self-checking bench for delay_line_ctrl.
module tb_delay_line_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [8:0] offset;
  logic       in_valid;
  logic [7:0] in_sample;
  logic       out_valid;
  logic [7:0] out_sample;
  logic       filled;

  int total;
  int bad;

  delay_line_ctrl #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .offset     (offset),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .filled     (filled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] s);
    in_valid  = v;
    in_sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en       = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_sample !== 8'd0 || filled !== 1'b0) begin
      $display("FAIL reset_async: got v=%b s=%0d f=%b want 0/0/0", out_valid, out_sample, filled);
      bad++;
    end
    do_reset();
    total++;
    if (out_valid !== 1'b0 || filled !== 1'b0) begin
      $display("FAIL reset_release: got v=%b f=%b want 0/0", out_valid, filled);
      bad++;
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    do_reset();
    offset = 9'd3;
    en     = 1'b1;
    step(1'b1, 8'd99);
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL basic_idle_ignore: out_valid=%b want 0", out_valid);
      bad++;
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(i));
      exp = (i <= 3) ? 8'd0 : 8'(i - 3);
      total++;
      if (out_valid !== 1'b1 || out_sample !== exp) begin
        $display("FAIL basic_out[%0d]: got v=%b s=%0d want v=1 s=%0d", i, out_valid, out_sample, exp);
        bad++;
      end
      total++;
      if (filled !== (i >= 3)) begin
        $display("FAIL basic_filled[%0d]: got %b want %b", i, filled, (i >= 3));
        bad++;
      end
    end
  endtask

  task automatic test_gapped();
    logic [5:0] pat;
    logic [7:0] smp [4];
    logic [7:0] exp [4];
    int         k;
    pat = 6'b101101;
    smp[0] = 8'd10; smp[1] = 8'd20; smp[2] = 8'd30; smp[3] = 8'd40;
    exp[0] = 8'd0;  exp[1] = 8'd0;  exp[2] = 8'd10; exp[3] = 8'd20;
    do_reset();
    offset = 9'd2;
    en     = 1'b1;
    step(1'b0, 8'd0);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (pat[5-i]) begin
        step(1'b1, smp[k]);
        total++;
        if (out_valid !== 1'b1 || out_sample !== exp[k]) begin
          $display("FAIL gapped_out[%0d]: got v=%b s=%0d want v=1 s=%0d", i, out_valid, out_sample, exp[k]);
          bad++;
        end
        k++;
      end else begin
        step(1'b0, 8'd77);
        total++;
        if (out_valid !== 1'b0) begin
          $display("FAIL gapped_gap[%0d]: out_valid=%b want 0", i, out_valid);
          bad++;
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    int         errs;
    do_reset();
    offset = 9'd511;
    en     = 1'b1;
    step(1'b0, 8'd0);
    errs = 0;
    for (int i = 0; i < 1100; i++) begin
      step(1'b1, 8'(i % 256));
      exp = (i >= 511) ? 8'((i - 511) % 256) : 8'd0;
      total++;
      if (out_valid !== 1'b1 || out_sample !== exp) begin
        bad++;
        errs++;
        if (errs <= 5) begin
          $display("FAIL wrap_out[%0d]: got v=%b s=%0d want v=1 s=%0d", i, out_valid, out_sample, exp);
        end
      end
    end
    total++;
    if (filled !== 1'b1) begin
      $display("FAIL wrap_filled: got %b want 1", filled);
      bad++;
    end
  endtask

  task automatic test_zero_offset();
    logic [7:0] exp;
    do_reset();
    offset = 9'd0;
    en     = 1'b1;
    step(1'b0, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 6) offset = 9'd5;
      step(1'b1, 8'(i));
      exp = 8'(i - 1);
      total++;
      if (out_valid !== 1'b1 || out_sample !== exp) begin
        $display("FAIL zero_off_out[%0d]: got v=%b s=%0d want v=1 s=%0d", i, out_valid, out_sample, exp);
        bad++;
      end
    end
    en = 1'b0;
    step(1'b1, 8'd9);
    total++;
    if (out_valid !== 1'b1 || out_sample !== 8'd8) begin
      $display("FAIL zero_off_last: got v=%b s=%0d want v=1 s=8", out_valid, out_sample);
      bad++;
    end
    step(1'b1, 8'd50);
    total++;
    if (out_valid !== 1'b0 || filled !== 1'b0) begin
      $display("FAIL zero_off_idle: got v=%b f=%b want 0/0", out_valid, filled);
      bad++;
    end
    en = 1'b1;
    step(1'b0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(100 + i));
      exp = (i < 5) ? 8'd0 : 8'(95 + i);
      total++;
      if (out_valid !== 1'b1 || out_sample !== exp) begin
        $display("FAIL reoffset_out[%0d]: got v=%b s=%0d want v=1 s=%0d", i, out_valid, out_sample, exp);
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp;
    do_reset();
    offset = 9'd4;
    en     = 1'b1;
    step(1'b0, 8'd0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 8'(i));
      exp = (i <= 4) ? 8'd0 : 8'(i - 4);
      total++;
      if (out_valid !== 1'b1 || out_sample !== exp) begin
        $display("FAIL rstrun_pre[%0d]: got v=%b s=%0d want v=1 s=%0d", i, out_valid, out_sample, exp);
        bad++;
      end
    end
    in_valid  = 1'b1;
    in_sample = 8'd7;
    rst_n     = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_sample !== 8'd0 || filled !== 1'b0) begin
      $display("FAIL rstrun_async: got v=%b s=%0d f=%b want 0/0/0", out_valid, out_sample, filled);
      bad++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'd8);
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rstrun_release: out_valid=%b want 0", out_valid);
      bad++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(200 + i));
      exp = (i < 4) ? 8'd0 : 8'(196 + i);
      total++;
      if (out_valid !== 1'b1 || out_sample !== exp) begin
        $display("FAIL rstrun_post[%0d]: got v=%b s=%0d want v=1 s=%0d", i, out_valid, out_sample, exp);
        bad++;
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    offset    = 9'd0;
    in_valid  = 1'b0;
    in_sample = 8'd0;
    do_reset();
    test_reset();
    test_basic();
    test_gapped();
    test_wrap();
    test_zero_offset();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
